// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore controller for the fetch/decode/execute loop.
// Outputs come from registers loaded with the decode of the next state. The one
// exception is the branch-taken term, which combines the registered "in BRANCH_ST"
// bit with the live datapath flags. The controller keeps no flag copies of its own.
module control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       decoded_instruction,
  input  logic             zero,
  input  logic             neg,
  input  logic             unsigned_overflow,
  input  logic             signed_overflow,
  output logic             branch,
  output logic             pc_enable,
  output logic             ir_enable,
  output logic             addr_sel,
  output logic             c_sel,
  output logic             white_reg_enable,
  output logic [1:0]       operation,
  output logic             ram_write_enable,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_LOAD, S_STORE, S_MOVE, S_ALU, S_BRANCH, S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cond_q, cond_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_en_q, pc_en_d;
  logic             ir_en_q, ir_en_d;
  logic             addr_q, addr_d;
  logic             csel_q, csel_d;
  logic             wre_q, wre_d;
  logic [1:0]       op_q, op_d;
  logic             rwe_q, rwe_d;
  logic             halted_q, halted_d;
  logic             br_st_q, br_st_d;
  logic             taken;

  // Next-state dispatch, then Moore output decode of the state being entered.
  always_comb begin
    state_d  = state_q;
    cond_d   = cond_q;
    cnt_d    = cnt_q;
    pc_en_d  = 1'b0;
    ir_en_d  = 1'b0;
    addr_d   = 1'b0;
    csel_d   = 1'b0;
    wre_d    = 1'b0;
    op_d     = 2'b00;
    rwe_d    = 1'b0;
    halted_d = 1'b0;
    br_st_d  = 1'b0;

    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        // Keep the opcode so the branch condition is still known in BRANCH_ST.
        cond_d = decoded_instruction;
        case (decoded_instruction)
          5'd1:                                  state_d = S_LOAD;
          5'd2:                                  state_d = S_STORE;
          5'd3:                                  state_d = S_MOVE;
          5'd4, 5'd5, 5'd6, 5'd7:                state_d = S_ALU;
          5'd8, 5'd9, 5'd10, 5'd11, 5'd12,
          5'd13, 5'd14, 5'd15, 5'd16:            state_d = S_BRANCH;
          5'd31:                                 state_d = S_HALT;
          default:                               state_d = S_FETCH;
        endcase
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase

    case (state_d)
      S_FETCH: begin
        pc_en_d = 1'b1;
        ir_en_d = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      S_LOAD: begin
        addr_d = 1'b1;
        csel_d = 1'b1;
        wre_d  = 1'b1;
      end
      S_STORE: begin
        addr_d = 1'b1;
        rwe_d  = 1'b1;
      end
      S_MOVE: begin
        op_d  = 2'b11;
        wre_d = 1'b1;
      end
      S_ALU: begin
        // Opcodes 4..7 map onto ALU ops 00..11 through their low two bits.
        op_d  = decoded_instruction[1:0];
        wre_d = 1'b1;
      end
      S_BRANCH: br_st_d  = 1'b1;
      S_HALT:   halted_d = 1'b1;
      default:  ;
    endcase
  end

  // State, counter and output registers; reset clears them all, which gives RESET all-zero outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RESET;
      cond_q   <= 5'd0;
      cnt_q    <= '0;
      pc_en_q  <= 1'b0;
      ir_en_q  <= 1'b0;
      addr_q   <= 1'b0;
      csel_q   <= 1'b0;
      wre_q    <= 1'b0;
      op_q     <= 2'b00;
      rwe_q    <= 1'b0;
      halted_q <= 1'b0;
      br_st_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cond_q   <= cond_d;
      cnt_q    <= cnt_d;
      pc_en_q  <= pc_en_d;
      ir_en_q  <= ir_en_d;
      addr_q   <= addr_d;
      csel_q   <= csel_d;
      wre_q    <= wre_d;
      op_q     <= op_d;
      rwe_q    <= rwe_d;
      halted_q <= halted_d;
      br_st_q  <= br_st_d;
    end
  end

  // Branch condition evaluated against the live registered flags from the datapath.
  always_comb begin
    taken = 1'b0;
    case (cond_q)
      5'd8:    taken = 1'b1;
      5'd9:    taken = zero;
      5'd10:   taken = ~zero;
      5'd11:   taken = neg;
      5'd12:   taken = ~neg;
      5'd13:   taken = signed_overflow;
      5'd14:   taken = ~signed_overflow;
      5'd15:   taken = unsigned_overflow;
      5'd16:   taken = ~unsigned_overflow;
      default: taken = 1'b0;
    endcase
  end

  assign branch           = br_st_q & taken;
  assign pc_enable        = pc_en_q | branch;
  assign addr_sel         = addr_q | branch;
  assign ir_enable        = ir_en_q;
  assign c_sel            = csel_q;
  assign white_reg_enable = wre_q;
  assign operation        = op_q;
  assign ram_write_enable = rwe_q;
  assign halted           = halted_q;
  assign instr_count      = cnt_q;

endmodule
